// File: rtl/entrada_operandos.sv
// entrada_operandos: captures operands A then B from shared switches on successive button presses.
// Optional debounce filter enabled by defining ENTRADA_OPERANDOS_DEBOUNCE_EN. Revision 1.0
`default_nettype none

module entrada_operandos #(
   parameter int DEBOUNCE_CICLOS = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] chaves,
   input  logic       botao,
   input  logic       limpar,
   output logic [3:0] A,
   output logic [3:0] B,
   output logic       valido,
   output logic [1:0] estado,
   output logic [7:0] op_cont
);

   typedef enum logic [1:0] {
      ESPERA_A = 2'b00,
      ESPERA_B = 2'b01,
      PRONTO   = 2'b10,
      ILEGAL   = 2'b11
   } estado_t;

   estado_t estado_atual;
   estado_t proximo;
   logic    sync1;
   logic    sync2;
   logic    nivel;
   logic    nivel_ant;
   logic    pulso;
   logic    captura_a;
   logic    captura_b;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
      end else begin
         sync1 <= botao;
         sync2 <= sync1;
      end
   end

`ifdef ENTRADA_OPERANDOS_DEBOUNCE_EN
   logic [15:0] deb_cont;
   logic        deb_nivel;

   // Any sample equal to the filtered level restarts the count.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         deb_cont  <= 16'd0;
         deb_nivel <= 1'b0;
      end else if (sync2 != deb_nivel) begin
         if (deb_cont == 16'(DEBOUNCE_CICLOS - 1)) begin
            deb_nivel <= sync2;
            deb_cont  <= 16'd0;
         end else begin
            deb_cont <= deb_cont + 16'd1;
         end
      end else begin
         deb_cont <= 16'd0;
      end
   end

   assign nivel = deb_nivel;
`else
   logic [31:0] debounce_unused;
   assign debounce_unused = DEBOUNCE_CICLOS;
   assign nivel = sync2;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         nivel_ant <= 1'b0;
      end else begin
         nivel_ant <= nivel;
      end
   end

   assign pulso = nivel & ~nivel_ant;

   always_comb begin
      proximo   = estado_atual;
      captura_a = 1'b0;
      captura_b = 1'b0;
      if (limpar) begin
         proximo = ESPERA_A;
      end else begin
         case (estado_atual)
            ESPERA_A: if (pulso) begin
               captura_a = 1'b1;
               proximo   = ESPERA_B;
            end
            ESPERA_B: if (pulso) begin
               captura_b = 1'b1;
               proximo   = PRONTO;
            end
            PRONTO:   if (pulso) proximo = ESPERA_A;
            ILEGAL:   proximo = ESPERA_A;
            default:  proximo = ESPERA_A;
         endcase
      end
   end

   // valido is decoded from the next state so it rises together with B.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         estado_atual <= ESPERA_A;
         valido       <= 1'b0;
         A            <= 4'd0;
         B            <= 4'd0;
         op_cont      <= 8'd0;
      end else begin
         estado_atual <= proximo;
         valido       <= (proximo == PRONTO);
         if (limpar) begin
            A       <= 4'd0;
            B       <= 4'd0;
            op_cont <= 8'd0;
         end else begin
            if (captura_a) A <= chaves;
            if (captura_b) begin
               B       <= chaves;
               op_cont <= op_cont + 8'd1;
            end
         end
      end
   end

   assign estado = estado_atual;

endmodule

`default_nettype wire
